// File: rtl/uart_tx_fifo.sv
// Byte-wide transmit FIFO feeding an 8N1 UART serializer.
// One clock, asynchronous active-high reset; the serial line idles high.
//
// state | meaning
// IDLE  | line high, waiting for the FIFO to hold a byte
// START | start bit (0) for CLK_DIV cycles
// DATA  | 8 data bits, LSB first, CLK_DIV cycles each
// STOP  | stop bit (1); on its last cycle, chain the next frame or go idle
module uart_tx_fifo #(
  parameter int CLK_DIV    = 5208,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       UART_TXD
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [15:0]           BAUD_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;

  logic push;
  logic pop;
  logic baud_done;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign busy      = (state != IDLE);
  assign push      = wr_en && !full;
  assign baud_done = (baud_cnt == BAUD_LAST);
  // Pops happen only from a non-empty FIFO, so a write into an empty FIFO
  // always waits one cycle before it can be launched.
  assign pop       = !empty && ((state == IDLE) || (state == STOP && baud_done));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      UART_TXD  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            state     <= START;
            bit_idx   <= '0;
            shift_reg <= mem[rd_ptr];
            UART_TXD  <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            state     <= DATA;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            UART_TXD  <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              UART_TXD <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              UART_TXD  <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            // Chain straight into the next start bit so frames sit back-to-back.
            if (pop) begin
              state     <= START;
              shift_reg <= mem[rd_ptr];
              UART_TXD  <= 1'b0;
            end else begin
              state    <= IDLE;
              UART_TXD <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
          UART_TXD <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLK_DIV=4: frame timing, back-to-back
// chaining, full/drop behaviour, async reset mid-frame and pointer wrap.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       busy;
  logic       UART_TXD;

  int total = 0;
  int bad   = 0;

  uart_tx_fifo #(.CLK_DIV(4), .DEPTH_LOG2(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .UART_TXD (UART_TXD)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that entered START (offset 0); checks the line
  // and busy for every cycle of the 40-cycle frame from offset 'skip' onward.
  // With 'poke', a write is attempted on the last STOP cycle while full.
  task automatic check_frame(input logic [7:0] b, input int skip, input bit poke);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = skip; k < 40; k++) begin
      chk("frame_txd", UART_TXD, fr[k/4]);
      chk("frame_busy", busy, 1);
      if (poke && k == 39) begin
        chk("full_before_pop", full, 1);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
      end
      tick;
    end
    if (poke) begin
      wr_en = 1'b0;
      chk("full_after_pop", full, 0);
    end
  endtask

  initial begin
    logic [7:0] rb;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;

    // Reset state
    #12;
    chk("rst_txd", UART_TXD, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    @(negedge clk);
    rst = 1'b0;
    tick;

    // Single byte 0x55: accepted at N, line low after N+1
    wr_en = 1'b1; wr_data = 8'h55;
    tick;
    wr_en = 1'b0; wr_data = 8'hC3;
    chk("n_txd", UART_TXD, 1);
    chk("n_empty", empty, 0);
    chk("n_busy", busy, 0);
    tick;
    chk("n1_empty", empty, 1);
    check_frame(8'h55, 0, 1'b0);
    chk("after55_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("after55_txd", UART_TXD, 1);
      tick;
    end

    // Ten consecutive writes: 0x09 dropped, 0x00..0x08 back-to-back
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick;
      if (i == 7) chk("full_before_9th", full, 0);
      if (i == 8) chk("full_after_9th", full, 1);
    end
    wr_en = 1'b0;
    chk("full_held", full, 1);
    check_frame(8'h00, 8, 1'b1);
    for (int i = 1; i < 9; i++) check_frame(8'(i), 0, 1'b0);
    chk("burst_busy_end", busy, 0);
    chk("burst_empty_end", empty, 1);
    chk("burst_txd_end", UART_TXD, 1);
    tick;
    chk("burst_idle_txd", UART_TXD, 1);

    // Async reset during data bit 4 of 0xA3 with a second byte queued
    wr_en = 1'b1; wr_data = 8'hA3;
    tick;
    wr_data = 8'h11;
    tick;
    wr_en = 1'b0;
    repeat (21) tick;
    chk("pre_rst_txd_bit4", UART_TXD, 0);
    chk("pre_rst_empty", empty, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_txd", UART_TXD, 1);
    chk("async_empty", empty, 1);
    chk("async_busy", busy, 0);
    chk("async_full", full, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick;
      chk("post_rst_txd", UART_TXD, 1);
      chk("post_rst_busy", busy, 0);
    end
    chk("post_rst_empty", empty, 1);

    // Pointer wrap: 20 random bytes, one per frame
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom_range(0, 255));
      wr_en = 1'b1; wr_data = rb;
      tick;
      wr_en = 1'b0; wr_data = ~rb;
      tick;
      check_frame(rb, 0, 1'b0);
      chk("wrap_idle", busy, 0);
    end
    chk("wrap_empty", empty, 1);

    // 0xFF then 0x00 back-to-back
    wr_en = 1'b1; wr_data = 8'hFF;
    tick;
    wr_data = 8'h00;
    tick;
    wr_en = 1'b0;
    check_frame(8'hFF, 0, 1'b0);
    check_frame(8'h00, 0, 1'b0);
    chk("ff00_busy_end", busy, 0);
    chk("ff00_txd_end", UART_TXD, 1);
    chk("ff00_empty_end", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
